// File: rtl/fifo_threshold.sv
// Single-clock FIFO with programmable almost-full/almost-empty flags and sticky error.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_threshold #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [2:0]        sup_Threshold,
    input  logic [2:0]        inf_Threshold,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              error
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              error_q, error_d;

    logic              push_ok;
    logic              pop_ok;
    logic [CNT_W-1:0]  sup_ext;
    logic [CNT_W-1:0]  inf_ext;

    // Status flags come straight from the count register and live thresholds.
    always_comb begin
        sup_ext      = CNT_W'(sup_Threshold);
        inf_ext      = CNT_W'(inf_Threshold);
        empty        = (count_q == '0);
        full         = (count_q == CNT_W'(DEPTH));
        almost_full  = (sup_Threshold != 3'd0) && (count_q >= sup_ext);
        almost_empty = (count_q <= inf_ext);
        count        = count_q;
        error        = error_q;
    end

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    always_comb begin
        push_ok = wr_en && (!full || rd_en);
        pop_ok  = rd_en && !empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if ((wr_en && !push_ok) || (rd_en && !pop_ok)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage is deliberately left out of reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    always_comb begin
        data_out  = mem[rd_ptr_q];
        valid_out = !empty;
    end
`else
    logic [DATA_W-1:0] data_out_q;
    logic              valid_out_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= pop_ok;
            if (pop_ok) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    always_comb begin
        data_out  = data_out_q;
        valid_out = valid_out_q;
    end
`endif

endmodule

// File: tb/tb_fifo_threshold.sv
// Randomized self-checking bench for fifo_threshold against a queue-based reference model.
// Honours FIFO_FWFT_EN the same way the design does.
module tb_fifo_threshold;

    logic       clk;
    logic       reset_L;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] sup_Threshold;
    logic [2:0] inf_Threshold;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       error;

    fifo_threshold #(
        .DATA_W(6),
        .ADDR_W(3)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .sup_Threshold(sup_Threshold),
        .inf_Threshold(inf_Threshold),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: the FIFO contents as a plain queue plus the visible registers.
    logic [5:0] model_q[$];
    logic [5:0] exp_dout;
    logic       exp_valid;
    logic       exp_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == 8));
        check_eq("almost_full", 32'(almost_full), 32'((sup_Threshold != 0) && (n >= sup_Threshold)));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= inf_Threshold));
        check_eq("error", 32'(error), 32'(exp_err));
`ifdef FIFO_FWFT_EN
        check_eq("valid_out", 32'(valid_out), 32'(n != 0));
        if (n != 0) begin
            check_eq("data_out", 32'(data_out), 32'(model_q[0]));
        end
`else
        check_eq("valid_out", 32'(valid_out), 32'(exp_valid));
        check_eq("data_out", 32'(data_out), 32'(exp_dout));
`endif
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic wr, input logic rd, input logic [5:0] d);
        bit push_ok;
        bit pop_ok;
        int n;
        wr_en   = wr;
        rd_en   = rd;
        data_in = d;
        #1;
        check_all();
        n       = model_q.size();
        push_ok = wr && ((n < 8) || rd);
        pop_ok  = rd && (n != 0);
        @(posedge clk);
        if ((wr && !push_ok) || (rd && !pop_ok)) exp_err = 1'b1;
        exp_valid = pop_ok;
        if (pop_ok) exp_dout = model_q.pop_front();
        if (push_ok) model_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reset_L = 1'b0;
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_L       = 1'b1;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        data_in       = '0;
        sup_Threshold = 3'd6;
        inf_Threshold = 3'd1;
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset while holding five words.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i + 3));
        check_all();
        do_reset();

        // Fill past full, then drain past empty.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 6'(8'h20 + i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);

        // Simultaneous push/pop on a full FIFO keeps order.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(8'h20 + i));
        step(1'b1, 1'b1, 6'h15);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);

        // Push and pop on empty: push taken, pop rejected.
        do_reset();
        step(1'b1, 1'b1, 6'h2B);
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);

        // Interleaved traffic wraps the pointers several times.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 6'($urandom));
            step(1'b1, (i % 3) != 0, 6'($urandom));
            step(1'b0, 1'b1, 6'h00);
        end

        // Single word shown and acknowledged.
        do_reset();
        step(1'b1, 1'b0, 6'h3A);
        step(1'b0, 1'b0, 6'h00);
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);

        // Random traffic with moving thresholds and occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) sup_Threshold = 3'($urandom);
            if ($urandom_range(0, 7) == 0) inf_Threshold = 3'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 6'($urandom));
            end
        end
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
